// File: rtl/reg_op_sequencer_if.sv
// rtl/reg_op_sequencer_if.sv - command and register-control bundle for reg_op_sequencer
//
// Purpose: groups the command handshake, abort/status and the register
// control/feedback signals of reg_op_sequencer into one bundle.
// Modports:
//   slave  - the sequencer: takes commands and reg_q, drives strobes and status
//   master - the control unit / register side: drives commands and reg_q
// Signals:
//   cmd_valid/cmd_ready   command handshake
//   cmd_op[2:0]           0 CLR,1 LOAD,2 INC,3 DEC,4 SHR,5 SHL,6 ROR,7 ROL
//   cmd_amt[CW-1:0]       step count (ignored for CLR/LOAD)
//   cmd_data[W-1:0]       load value
//   abort                 stop current command early
//   reg_q[W-1:0]          register contents fed back for rotates
//   reg_cl..reg_sl        single-cycle register strobes
//   reg_in[W-1:0]         register load data
//   reg_ir/reg_il         serial fill bits for right/left shift
//   busy/done/aborted     status
interface reg_op_sequencer_if #(
  parameter int W  = 4,
  parameter int CW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [CW-1:0] cmd_amt;
  logic [W-1:0]  cmd_data;
  logic          abort;
  logic [W-1:0]  reg_q;
  logic          reg_cl;
  logic          reg_ld;
  logic          reg_inc;
  logic          reg_dec;
  logic          reg_sr;
  logic          reg_sl;
  logic [W-1:0]  reg_in;
  logic          reg_ir;
  logic          reg_il;
  logic          busy;
  logic          done;
  logic          aborted;

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_data, abort, reg_q,
    output cmd_ready, reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl,
    output reg_in, reg_ir, reg_il, busy, done, aborted
  );

  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_data, abort, reg_q,
    input  cmd_ready, reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl,
    input  reg_in, reg_ir, reg_il, busy, done, aborted
  );
endinterface

// File: rtl/reg_op_sequencer.sv
// rtl/reg_op_sequencer.sv - expands multi-step register commands into control strobes
//
// Purpose: accepts one command per cmd_valid/cmd_ready handshake and issues
// one register strobe per cycle for the requested number of steps, then
// pulses done for one cycle (with aborted qualifying an early stop).
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - reg_op_sequencer_if.slave (command, abort, register control/feedback, status)
module reg_op_sequencer #(
  parameter int W  = 4,
  parameter int CW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_op_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_CLR  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_ROR  = 3'd6;
  localparam logic [2:0] OP_ROL  = 3'd7;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  data_q, data_d;
  logic          aborted_q, aborted_d;
  logic [CW-1:0] cmd_steps;

  // CLR and LOAD are always a single step; the amount field only counts for
  // the repeatable ops.
  assign cmd_steps = (bus.cmd_op == OP_CLR || bus.cmd_op == OP_LOAD) ? CW'(1) : bus.cmd_amt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      data_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      data_q    <= data_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    data_d      = data_q;
    aborted_d   = aborted_q;
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.aborted   = aborted_q;
    bus.reg_cl    = 1'b0;
    bus.reg_ld    = 1'b0;
    bus.reg_inc   = 1'b0;
    bus.reg_dec   = 1'b0;
    bus.reg_sr    = 1'b0;
    bus.reg_sl    = 1'b0;
    bus.reg_in    = data_q;
    // Rotates are shifts whose fill bit is the bit falling off the other end.
    bus.reg_ir    = (op_q == OP_ROR) ? bus.reg_q[0]   : 1'b0;
    bus.reg_il    = (op_q == OP_ROL) ? bus.reg_q[W-1] : 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cmd_valid) begin
          op_d      = bus.cmd_op;
          data_d    = bus.cmd_data;
          cnt_d     = cmd_steps;
          aborted_d = 1'b0;
          // A zero-step command still completes with a done pulse.
          state_d   = (cmd_steps != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        case (op_q)
          OP_CLR:         bus.reg_cl  = 1'b1;
          OP_LOAD:        bus.reg_ld  = 1'b1;
          OP_INC:         bus.reg_inc = 1'b1;
          OP_DEC:         bus.reg_dec = 1'b1;
          OP_SHR, OP_ROR: bus.reg_sr  = 1'b1;
          OP_SHL, OP_ROL: bus.reg_sl  = 1'b1;
          default:        bus.reg_cl  = 1'b0;
        endcase
        cnt_d = cnt_q - CW'(1);
        if (bus.abort) begin
          // This cycle's strobe still goes out; aborted only if steps remain.
          state_d   = S_DONE;
          aborted_d = (cnt_q > CW'(1));
        end else if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_d   = S_IDLE;
        cnt_d     = '0;
        aborted_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// tb/tb_reg_op_sequencer.sv - self-checking bench for reg_op_sequencer
module tb_reg_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_op_sequencer_if #(.W(4), .CW(3)) bus ();

  reg_op_sequencer #(.W(4), .CW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural 4-bit register controlled by the sequencer's strobes.
  logic [3:0] reg_val = 4'h0;
  always @(posedge clk) begin
    if (bus.reg_cl)       reg_val <= 4'h0;
    else if (bus.reg_ld)  reg_val <= bus.reg_in;
    else if (bus.reg_inc) reg_val <= reg_val + 4'd1;
    else if (bus.reg_dec) reg_val <= reg_val - 4'd1;
    else if (bus.reg_sr)  reg_val <= {bus.reg_ir, reg_val[3:1]};
    else if (bus.reg_sl)  reg_val <= {reg_val[2:0], bus.reg_il};
  end
  assign bus.reg_q = reg_val;

  logic [5:0] strb;
  assign strb = {bus.reg_cl, bus.reg_ld, bus.reg_inc, bus.reg_dec, bus.reg_sr, bus.reg_sl};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which strobe an op uses, as {cl,ld,inc,dec,sr,sl}.
  function automatic logic [5:0] strobe_of(input logic [2:0] op);
    case (op)
      3'd0:       return 6'b100000;
      3'd1:       return 6'b010000;
      3'd2:       return 6'b001000;
      3'd3:       return 6'b000100;
      3'd4, 3'd6: return 6'b000010;
      default:    return 6'b000001;
    endcase
  endfunction

  // Register value after n steps of op, computed arithmetically.
  function automatic logic [3:0] model_final(input logic [2:0] op, input int n,
                                             input logic [3:0] v, input logic [3:0] d);
    int x;
    int r;
    x = int'(v);
    r = n % 4;
    case (op)
      3'd0:    return 4'h0;
      3'd1:    return d;
      3'd2:    return 4'(x + n);
      3'd3:    return 4'(x - n);
      3'd4:    return 4'(x >> n);
      3'd5:    return 4'(x << n);
      3'd6:    return 4'((x >> r) | (x << (4 - r)));
      default: return 4'((x << r) | (x >> (4 - r)));
    endcase
  endfunction

  // Issue one command, follow it cycle by cycle, and check against the model.
  // abort_at = k (1-based) raises abort during the k-th strobe cycle; 0 = none.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] amt, input logic [3:0] data,
                         input int abort_at, input string tag);
    int steps;
    int issued;
    logic exp_ab;
    logic [3:0] v0;
    bit seen;
    @(negedge clk);
    for (int k = 0; k < 20 && !bus.cmd_ready; k++) @(negedge clk);
    chk({tag, " ready"}, bus.cmd_ready, 1);
    v0     = reg_val;
    steps  = (op <= 3'd1) ? 1 : int'(amt);
    exp_ab = (abort_at >= 1 && abort_at < steps);
    issued = exp_ab ? abort_at : steps;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_amt   = amt;
    bus.cmd_data  = data;
    seen = 0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.abort     = 1'b0;
      if (bus.done) begin
        seen = 1;
        chk({tag, " done_cycle"}, c, issued + 1);
        chk({tag, " aborted"}, bus.aborted, exp_ab);
        chk({tag, " done_strobes"}, strb, 0);
        chk({tag, " done_busy_ready"}, {bus.busy, bus.cmd_ready}, 2'b10);
        chk({tag, " final"}, reg_val, model_final(op, issued, v0, data));
      end else begin
        chk({tag, " strobe"}, strb, strobe_of(op));
        chk({tag, " reg_in"}, bus.reg_in, data);
        chk({tag, " ir"}, bus.reg_ir, (op == 3'd6) ? reg_val[0] : 1'b0);
        chk({tag, " il"}, bus.reg_il, (op == 3'd7) ? reg_val[3] : 1'b0);
        bus.abort = (c == abort_at);
      end
    end
    bus.abort = 1'b0;
    if (!seen) chk({tag, " done_seen"}, 0, 1);
    @(negedge clk);
    chk({tag, " back_idle"}, {bus.busy, bus.done, bus.aborted, bus.cmd_ready}, 4'b0001);
  endtask

  initial begin
    logic [3:0] v0;
    logic [2:0] rop;
    logic [2:0] ramt;
    logic [3:0] rdat;
    int rab;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_amt   = 3'd0;
    bus.cmd_data  = 4'h0;
    bus.abort     = 1'b0;

    #1;
    chk("reset_ready", bus.cmd_ready, 1);
    chk("reset_strobes", strb, 0);
    chk("reset_status", {bus.busy, bus.done, bus.aborted}, 3'b000);
    chk("reset_reg_in", bus.reg_in, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_cmd(3'd1, 3'd5, 4'hA, 0, "load_a");
    chk("load_a_val", reg_val, 4'hA);
    run_cmd(3'd1, 3'd0, 4'hE, 0, "load_e");
    run_cmd(3'd2, 3'd3, 4'h0, 0, "inc3_wrap");
    chk("inc3_wrap_val", reg_val, 4'h1);
    run_cmd(3'd1, 3'd0, 4'h9, 0, "load_9a");
    run_cmd(3'd7, 3'd2, 4'h0, 0, "rol2");
    chk("rol2_val", reg_val, 4'b0110);
    run_cmd(3'd1, 3'd0, 4'h9, 0, "load_9b");
    run_cmd(3'd6, 3'd1, 4'h0, 0, "ror1");
    chk("ror1_val", reg_val, 4'b1100);
    run_cmd(3'd1, 3'd0, 4'h8, 0, "load_8");
    run_cmd(3'd4, 3'd7, 4'h0, 2, "shr7_abort2");
    chk("shr7_abort2_val", reg_val, 4'h2);
    run_cmd(3'd3, 3'd0, 4'h0, 0, "dec0");
    run_cmd(3'd2, 3'd3, 4'h0, 3, "abort_last");

    // cmd_valid held through a busy period: second command waits for IDLE.
    @(negedge clk);
    v0 = reg_val;
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd2; bus.cmd_amt = 3'd2;
    @(negedge clk);
    bus.cmd_op = 3'd3; bus.cmd_amt = 3'd1;
    chk("hold_r1", {bus.cmd_ready, strb}, {1'b0, 6'b001000});
    @(negedge clk);
    chk("hold_r2", {bus.cmd_ready, strb}, {1'b0, 6'b001000});
    @(negedge clk);
    chk("hold_done", {bus.cmd_ready, bus.done}, 2'b01);
    @(negedge clk);
    chk("hold_idle", {bus.cmd_ready, bus.busy}, 2'b10);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("hold_second_strobe", strb, 6'b000100);
    @(negedge clk);
    chk("hold_second_done", bus.done, 1);
    chk("hold_val", reg_val, 4'(v0 + 4'd1));

    // Randomized commands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rop  = 3'($urandom_range(0, 7));
      ramt = 3'($urandom_range(0, 7));
      rdat = 4'($urandom_range(0, 15));
      rab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      run_cmd(rop, ramt, rdat, rab, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a command.
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd2; bus.cmd_amt = 3'd5;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("rst_mid_run", strb, 6'b001000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_strobes", strb, 0);
    chk("rst_mid_status", {bus.cmd_ready, bus.busy, bus.done, bus.aborted}, 4'b1000);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_mid_no_done", {bus.done, strb, bus.cmd_ready}, {1'b0, 6'b0, 1'b1});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
